// File: rtl/tmcuart_phy.sv
// tmcuart_phy: byte-level half-duplex 8N1 serial engine for the TMC UART
// sequencer. Independent TX and RX state machines, each with its own
// prescaler; one bit lasts four prescaler ticks (BP = 4*CLOCK_DIVIDE clk).
module tmcuart_phy #(
   parameter int CLOCK_DIVIDE = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error
);

   // A divide of 1 still needs a 1-bit prescaler that simply never advances.
   localparam int PW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_DIVIDE - 1);

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [2:0] RX_IDLE    = 3'd0;
   localparam logic [2:0] RX_START   = 3'd1;
   localparam logic [2:0] RX_DATA    = 3'd2;
   localparam logic [2:0] RX_STOP    = 3'd3;
   localparam logic [2:0] RX_RECOVER = 3'd4;

   // ---------------------------------------------------------------- TX
   logic [1:0]    tx_state_reg;
   logic [PW-1:0] tx_presc_reg;
   logic [1:0]    tx_tick_cnt_reg;
   logic [3:0]    tx_bit_cnt_reg;
   logic [7:0]    tx_shift_reg;
   logic          tx_reg;
   logic          tx_tick;
   logic          tx_bit_end;

   assign tx_tick    = (tx_presc_reg == PRESC_MAX);
   // Last clk cycle of the current bit: fourth tick since the bit began.
   assign tx_bit_end = tx_tick && (tx_tick_cnt_reg == 2'd3);

   // TX FSM with its prescaler; the prescaler restarts on every accepted byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_reg    <= TX_IDLE;
         tx_presc_reg    <= '0;
         tx_tick_cnt_reg <= 2'd0;
         tx_bit_cnt_reg  <= 4'd0;
         tx_shift_reg    <= 8'd0;
         tx_reg          <= 1'b1;
      end else begin
         if (tx_state_reg == TX_IDLE) begin
            if (transmit) begin
               tx_shift_reg    <= tx_byte;
               tx_reg          <= 1'b0;
               tx_presc_reg    <= '0;
               tx_tick_cnt_reg <= 2'd0;
               tx_bit_cnt_reg  <= 4'd0;
               tx_state_reg    <= TX_START;
            end
         end else begin
            tx_presc_reg <= tx_tick ? '0 : tx_presc_reg + PW'(1);
            if (tx_tick) begin
               tx_tick_cnt_reg <= tx_tick_cnt_reg + 2'd1;
            end
            if (tx_bit_end) begin
               case (tx_state_reg)
                  TX_START: begin
                     tx_reg         <= tx_shift_reg[0];
                     tx_shift_reg   <= {1'b0, tx_shift_reg[7:1]};
                     tx_bit_cnt_reg <= 4'd0;
                     tx_state_reg   <= TX_DATA;
                  end
                  TX_DATA: begin
                     if (tx_bit_cnt_reg == 4'd7) begin
                        tx_reg         <= 1'b1;
                        tx_bit_cnt_reg <= 4'd0;
                        tx_state_reg   <= TX_STOP;
                     end else begin
                        tx_reg         <= tx_shift_reg[0];
                        tx_shift_reg   <= {1'b0, tx_shift_reg[7:1]};
                        tx_bit_cnt_reg <= tx_bit_cnt_reg + 4'd1;
                     end
                  end
                  TX_STOP: begin
                     tx_state_reg <= TX_IDLE;
                  end
                  default: begin
                     tx_state_reg <= TX_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign tx              = tx_reg;
   assign is_transmitting = (tx_state_reg != TX_IDLE);

   // ---------------------------------------------------------------- RX
   logic [1:0]    rx_sync_reg;
   logic          rxs;
   logic [2:0]    rx_state_reg;
   logic [PW-1:0] rx_presc_reg;
   logic [1:0]    rx_tick_cnt_reg;
   logic [3:0]    rx_bit_cnt_reg;
   logic [7:0]    rx_shift_reg;
   logic [7:0]    rx_byte_reg;
   logic          received_reg;
   logic          recv_error_reg;
   logic          rx_tick;
   logic          rx_sample;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync_reg <= 2'b11;
      end else begin
         rx_sync_reg <= {rx_sync_reg[0], rx};
      end
   end

   assign rxs       = rx_sync_reg[1];
   assign rx_tick   = (rx_presc_reg == PRESC_MAX);
   // Mid-bit point: second tick after start detection, then every fourth.
   assign rx_sample = rx_tick && (rx_tick_cnt_reg == 2'd1);

   // RX FSM with its prescaler; result pulses are registered one-cycle strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_reg    <= RX_IDLE;
         rx_presc_reg    <= '0;
         rx_tick_cnt_reg <= 2'd0;
         rx_bit_cnt_reg  <= 4'd0;
         rx_shift_reg    <= 8'd0;
         rx_byte_reg     <= 8'd0;
         received_reg    <= 1'b0;
         recv_error_reg  <= 1'b0;
      end else begin
         received_reg   <= 1'b0;
         recv_error_reg <= 1'b0;
         if (rx_state_reg == RX_IDLE) begin
            if (!rxs) begin
               rx_presc_reg    <= '0;
               rx_tick_cnt_reg <= 2'd0;
               rx_bit_cnt_reg  <= 4'd0;
               rx_state_reg    <= RX_START;
            end
         end else begin
            rx_presc_reg <= rx_tick ? '0 : rx_presc_reg + PW'(1);
            if (rx_tick) begin
               rx_tick_cnt_reg <= rx_tick_cnt_reg + 2'd1;
            end
            case (rx_state_reg)
               RX_START: begin
                  if (rx_sample) begin
                     if (rxs) begin
                        recv_error_reg <= 1'b1;
                        rx_state_reg   <= RX_IDLE;
                     end else begin
                        rx_bit_cnt_reg <= 4'd0;
                        rx_state_reg   <= RX_DATA;
                     end
                  end
               end
               RX_DATA: begin
                  if (rx_sample) begin
                     rx_shift_reg <= {rxs, rx_shift_reg[7:1]};
                     if (rx_bit_cnt_reg == 4'd7) begin
                        rx_bit_cnt_reg <= 4'd0;
                        rx_state_reg   <= RX_STOP;
                     end else begin
                        rx_bit_cnt_reg <= rx_bit_cnt_reg + 4'd1;
                     end
                  end
               end
               RX_STOP: begin
                  if (rx_sample) begin
                     if (rxs) begin
                        rx_byte_reg  <= rx_shift_reg;
                        received_reg <= 1'b1;
                        rx_state_reg <= RX_IDLE;
                     end else begin
                        recv_error_reg <= 1'b1;
                        rx_state_reg   <= RX_RECOVER;
                     end
                  end
               end
               RX_RECOVER: begin
                  // Wait out a stuck-low line so it cannot be read as new frames.
                  if (rxs) begin
                     rx_state_reg <= RX_IDLE;
                  end
               end
               default: begin
                  rx_state_reg <= RX_IDLE;
               end
            endcase
         end
      end
   end

   assign rx_byte      = rx_byte_reg;
   assign received     = received_reg;
   assign recv_error   = recv_error_reg;
   assign is_receiving = (rx_state_reg != RX_IDLE);

endmodule

// File: tb/tb_tmcuart_phy.sv
// Testbench for tmcuart_phy with CLOCK_DIVIDE=4 (BP=16). Expected line levels
// and status outputs come from a cycle-indexed frame model of the 8N1 format.
module tb_tmcuart_phy;

   localparam int CD = 4;
   localparam int BP = 4 * CD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       tx;
   logic       transmit = 1'b0;
   logic [7:0] tx_byte = 8'd0;
   logic       received;
   logic [7:0] rx_byte;
   logic       is_receiving;
   logic       is_transmitting;
   logic       recv_error;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] model_rx_byte = 8'd0;

   tmcuart_phy #(.CLOCK_DIVIDE(CD)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .tx(tx),
      .transmit(transmit),
      .tx_byte(tx_byte),
      .received(received),
      .rx_byte(rx_byte),
      .is_receiving(is_receiving),
      .is_transmitting(is_transmitting),
      .recv_error(recv_error)
   );

   always #5 clk = ~clk;

   // Line level t cycles into a frame (t=1 is the first start-bit cycle).
   function automatic logic frame_bit(input int t, input logic [7:0] b, input logic stop_bit);
      int idx;
      if (t < 1 || t > 10 * BP) return 1'b1;
      idx = (t - 1) / BP;
      if (idx == 0) return 1'b0;
      if (idx == 9) return stop_bit;
      return b[idx - 1];
   endfunction

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b want=1", tx); end
      n_checks++;
      if ({received, recv_error, is_receiving, is_transmitting} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_status got=%b want=0000", {received, recv_error, is_receiving, is_transmitting});
      end
      n_checks++;
      if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte got=%h want=00", rx_byte); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("test_reset done");
   endtask

   // Send b1; optionally pulse transmit again with b2 at cycle t2 after acceptance.
   // The second request is only honoured once the first frame has fully ended.
   task automatic test_tx(input logic [7:0] b1, input logic [7:0] b2, input int t2, input string name);
      bit   acc;
      int   tend;
      int   u;
      logic e_tx;
      logic e_busy;
      int   errs;
      acc  = (t2 > 10 * BP);
      tend = acc ? t2 + 10 * BP + 4 : 10 * BP + 4;
      errs = n_fail;
      @(negedge clk);
      transmit = 1'b1;
      tx_byte  = b1;
      for (int t = 1; t <= tend; t++) begin
         @(negedge clk);
         if (acc && t > t2) begin
            u      = t - t2;
            e_tx   = frame_bit(u, b2, 1'b1);
            e_busy = (u <= 10 * BP);
         end else begin
            e_tx   = frame_bit(t, b1, 1'b1);
            e_busy = (t <= 10 * BP);
         end
         n_checks++;
         if (tx !== e_tx) begin
            n_fail++;
            $display("FAIL %s tx cycle %0d got=%b want=%b", name, t, tx, e_tx);
         end
         n_checks++;
         if (is_transmitting !== e_busy) begin
            n_fail++;
            $display("FAIL %s is_transmitting cycle %0d got=%b want=%b", name, t, is_transmitting, e_busy);
         end
         transmit = (t == t2);
         tx_byte  = (t == t2) ? b2 : 8'($urandom);
      end
      transmit = 1'b0;
      $display("%s: byte=%h second=%h at %0d accepted=%0d errors=%0d", name, b1, b2, t2, acc, n_fail - errs);
   endtask

   // Drive one RX scenario: a frame (good or bad stop bit, optional extra low
   // time) or, with glitch_len>0, a short low pulse. Checks every cycle.
   task automatic test_rx(input logic [7:0] b, input logic stop_bit, input int low_extra,
                          input int glitch_len, input string name);
      bit   good;
      int   pulse_c;
      int   rx_end;
      int   tend;
      int   errs;
      logic e_busy;
      logic e_recv;
      logic e_err;
      good = (glitch_len == 0) && stop_bit;
      errs = n_fail;
      // rxs first reads 0 in cycle 3 (two synchronizer stages after cycle 1).
      if (glitch_len > 0) begin
         pulse_c = 4 + BP / 2;
         rx_end  = 3 + BP / 2;
      end else if (stop_bit) begin
         pulse_c = 4 + BP / 2 + 9 * BP;
         rx_end  = 3 + BP / 2 + 9 * BP;
      end else begin
         pulse_c = 4 + BP / 2 + 9 * BP;
         rx_end  = 10 * BP + low_extra + 3;
      end
      tend = rx_end + 20;
      for (int c = 1; c <= tend; c++) begin
         @(negedge clk);
         if (good && c == pulse_c) model_rx_byte = b;
         e_busy = (c >= 4) && (c <= rx_end);
         e_recv = good && (c == pulse_c);
         e_err  = !good && (c == pulse_c);
         n_checks++;
         if (is_receiving !== e_busy) begin
            n_fail++;
            $display("FAIL %s is_receiving cycle %0d got=%b want=%b", name, c, is_receiving, e_busy);
         end
         n_checks++;
         if (received !== e_recv) begin
            n_fail++;
            $display("FAIL %s received cycle %0d got=%b want=%b", name, c, received, e_recv);
         end
         n_checks++;
         if (recv_error !== e_err) begin
            n_fail++;
            $display("FAIL %s recv_error cycle %0d got=%b want=%b", name, c, recv_error, e_err);
         end
         n_checks++;
         if (rx_byte !== model_rx_byte) begin
            n_fail++;
            $display("FAIL %s rx_byte cycle %0d got=%h want=%h", name, c, rx_byte, model_rx_byte);
         end
         if (glitch_len > 0) rx = (c <= glitch_len) ? 1'b0 : 1'b1;
         else if (!stop_bit && c > 10 * BP && c <= 10 * BP + low_extra) rx = 1'b0;
         else rx = frame_bit(c, b, stop_bit);
      end
      rx = 1'b1;
      $display("%s: byte=%h stop=%b extra_low=%0d glitch=%0d errors=%0d", name, b, stop_bit, low_extra,
               glitch_len, n_fail - errs);
   endtask

   // Reset in the middle of TX data bit 3 and RX data bit 5, then resend.
   task automatic test_reset_mid();
      logic [7:0] rb;
      logic [7:0] tb;
      rb = 8'($urandom);
      tb = 8'($urandom);
      for (int c = 1; c <= 103; c++) begin
         @(negedge clk);
         rx       = frame_bit(c, rb, 1'b1);
         transmit = (c == 32);
         tx_byte  = tb;
      end
      @(negedge clk);
      n_checks++;
      if ({is_transmitting, is_receiving} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_mid busy_before got=%b want=11", {is_transmitting, is_receiving});
      end
      n_checks++;
      if (tx !== tb[3]) begin n_fail++; $display("FAIL reset_mid tx_bit3 got=%b want=%b", tx, tb[3]); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_mid tx got=%b want=1", tx); end
      n_checks++;
      if ({received, recv_error, is_receiving, is_transmitting} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid status got=%b want=0000", {received, recv_error, is_receiving, is_transmitting});
      end
      n_checks++;
      if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_mid rx_byte got=%h want=00", rx_byte); end
      model_rx_byte = 8'h00;
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      $display("test_reset_mid: tx=%h rx=%h", tb, rb);
      test_tx(8'($urandom), 8'h00, -1, "tx_after_reset");
   endtask

   initial begin
      test_reset();
      test_tx(8'hA0, 8'h00, -1, "tx_a0");
      test_tx(8'hA0, 8'h55, 40, "tx_busy");
      test_tx(8'($urandom), 8'($urandom), 10 * BP, "tx_last_stop_cycle");
      for (int i = 0; i < 3; i++) begin
         test_tx(8'($urandom), 8'($urandom), int'($urandom_range(1, 10 * BP)), "tx_rand_ignored");
      end
      test_tx(8'($urandom), 8'($urandom), 10 * BP + 1, "tx_back_to_back");
      test_rx(8'h05, 1'b1, 0, 0, "rx_05");
      for (int i = 0; i < 3; i++) begin
         test_rx(8'($urandom), 1'b1, 0, 0, "rx_rand");
      end
      test_rx(8'h00, 1'b1, 0, int'($urandom_range(1, 6)), "rx_glitch");
      test_rx(8'hFF, 1'b1, 0, 0, "rx_ff_after_glitch");
      test_rx(8'h3C, 1'b0, 40, 0, "rx_framing");
      test_rx(8'h11, 1'b1, 0, 0, "rx_11_after_framing");
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
